// File: rtl/gate_pwm_monitor.sv
// gate_pwm_monitor: measures high pulses on the gate servo PWM line,
// classifies each one as OPEN / CLOSED / INVALID, debounces the class into
// a gate-position state, and flags stuck-high drive and a silent line.
module gate_pwm_monitor #(
  parameter int OPEN_MIN   = 70000,
  parameter int OPEN_MAX   = 80000,
  parameter int CLOSED_MIN = 20000,
  parameter int CLOSED_MAX = 30000,
  parameter int STUCK_MAX  = 200000,
  parameter int TIMEOUT    = 2000000,
  parameter int CONFIRM    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [17:0] pulse_width,
  output logic        width_valid,
  output logic        gate_open,
  output logic        gate_closed,
  output logic        fault,
  output logic        idle,
  output logic [15:0] frame_cnt
);

  localparam int RW = (CONFIRM < 3) ? 2 : $clog2(CONFIRM + 1);

  localparam logic [17:0]   OPEN_MIN_W   = 18'(OPEN_MIN);
  localparam logic [17:0]   OPEN_MAX_W   = 18'(OPEN_MAX);
  localparam logic [17:0]   CLOSED_MIN_W = 18'(CLOSED_MIN);
  localparam logic [17:0]   CLOSED_MAX_W = 18'(CLOSED_MAX);
  localparam logic [17:0]   STUCK_W      = 18'(STUCK_MAX);
  localparam logic [20:0]   TIMEOUT_W    = 21'(TIMEOUT);
  localparam logic [RW-1:0] CONFIRM_W    = RW'(CONFIRM);

  typedef enum logic [1:0] {ST_UNKNOWN, ST_OPEN, ST_CLOSED, ST_FAULT} state_e;
  typedef enum logic [1:0] {CL_NONE, CL_OPEN, CL_CLOSED, CL_INV} cls_e;

  logic          s1_q, s2_q, s3_q;
  logic [1:0]    sv_q;        // synchronizer fill: sv_q[1] => s2 reflects real input
  logic          armed_q;
  logic          hi_act_q;    // a measured pulse is in progress
  logic [17:0]   hi_cnt_q;
  logic          fall_q;
  logic [20:0]   idle_cnt_q, idle_cnt_d;
  logic [RW-1:0] run_q, run_d;
  cls_e          last_q, last_d, cls;
  state_e        state_q, state_d;
  logic          rise, fall, stuck;

  assign rise  = s2_q & ~s3_q & armed_q;
  assign fall  = ~s2_q & s3_q & hi_act_q;
  assign stuck = hi_act_q & s2_q & (hi_cnt_q == STUCK_W - 18'd1);

  // Synchronize the line; arm only once a genuine low has been seen so a
  // pulse already high at reset release is never measured.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0; s2_q <= 1'b0; s3_q <= 1'b0;
      sv_q <= 2'b00; armed_q <= 1'b0;
    end else begin
      s1_q    <= pwm_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      sv_q    <= {sv_q[0], 1'b1};
      armed_q <= armed_q | (sv_q[1] & ~s2_q);
    end
  end

  // High-time counter; a stuck pulse is abandoned so its fall is never reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_act_q <= 1'b0; hi_cnt_q <= '0; fall_q <= 1'b0;
    end else begin
      fall_q <= fall;
      if (rise) begin
        hi_act_q <= 1'b1;
        hi_cnt_q <= 18'd1;
      end else if (stuck) begin
        hi_act_q <= 1'b0;
        hi_cnt_q <= STUCK_W;
      end else if (fall) begin
        hi_act_q <= 1'b0;
      end else if (hi_act_q && s2_q) begin
        hi_cnt_q <= hi_cnt_q + 18'd1;
      end
    end
  end

  // Classify the held width (stable from fall until the next rise).
  always_comb begin
    cls = CL_INV;
    if (hi_cnt_q >= OPEN_MIN_W && hi_cnt_q <= OPEN_MAX_W)
      cls = CL_OPEN;
    else if (hi_cnt_q >= CLOSED_MIN_W && hi_cnt_q <= CLOSED_MAX_W)
      cls = CL_CLOSED;
  end

  // Confirm run and next state: stuck forces FAULT, otherwise CONFIRM equal classes move it.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    last_d  = last_q;
    if (stuck) begin
      state_d = ST_FAULT;
      run_d   = '0;
    end else if (fall_q) begin
      if (cls == last_q) begin
        if (run_q != CONFIRM_W) run_d = run_q + RW'(1);
      end else begin
        run_d  = RW'(1);
        last_d = cls;
      end
      if (run_d == CONFIRM_W) begin
        case (cls)
          CL_OPEN:   state_d = ST_OPEN;
          CL_CLOSED: state_d = ST_CLOSED;
          default:   state_d = ST_FAULT;
        endcase
      end
    end
  end

  // State and confirm registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_UNKNOWN; run_q <= '0; last_q <= CL_NONE;
    end else begin
      state_q <= state_d; run_q <= run_d; last_q <= last_d;
    end
  end

  // Idle counter: cleared by a rise, otherwise counts up and holds at TIMEOUT.
  always_comb begin
    if (rise)                       idle_cnt_d = '0;
    else if (idle_cnt_q >= TIMEOUT_W) idle_cnt_d = idle_cnt_q;
    else                            idle_cnt_d = idle_cnt_q + 21'd1;
  end

  // Registered outputs: width strobe, frame count, one-hot state decode, idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q  <= '0;
      pulse_width <= '0; width_valid <= 1'b0; frame_cnt <= '0;
      gate_open   <= 1'b0; gate_closed <= 1'b0; fault <= 1'b0; idle <= 1'b0;
    end else begin
      idle_cnt_q  <= idle_cnt_d;
      idle        <= (idle_cnt_d >= TIMEOUT_W);
      width_valid <= fall_q;
      if (fall_q) begin
        pulse_width <= hi_cnt_q;
        frame_cnt   <= frame_cnt + 16'd1;
      end
      gate_open   <= (state_q == ST_OPEN);
      gate_closed <= (state_q == ST_CLOSED);
      fault       <= (state_q == ST_FAULT);
    end
  end

endmodule
